// File: rtl/cpu5_mem_arbiter.sv
// cpu5_mem_arbiter
// Shares one single-ported memory between instruction fetch (IFU) and
// load/store (LSU). One transaction is outstanding at a time. LSU has
// priority; after MAX_STREAK consecutive LSU grants with IFU waiting, IFU
// is granted next.
//
// Ports:
//   clk, reset         clock, async active-high reset
//   ifu_req/addr       fetch read request (held until ifu_gnt)
//   ifu_gnt            one-cycle pulse when fetch request is taken
//   ifu_rvalid/rdata   fetch read response
//   lsu_req/we/addr/wdata  load/store request (held until lsu_gnt)
//   lsu_gnt            one-cycle pulse when data request is taken
//   lsu_rvalid/rdata   load read response
//   mem_req/we/addr/wdata  registered memory request, stable until mem_ready
//   mem_ready          memory accepts the request
//   mem_rvalid/rdata   memory read response
module cpu5_mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ifu_req,
    input  logic [XLEN-1:0] ifu_addr,
    output logic            ifu_gnt,
    output logic            ifu_rvalid,
    output logic [XLEN-1:0] ifu_rdata,
    input  logic            lsu_req,
    input  logic            lsu_we,
    input  logic [XLEN-1:0] lsu_addr,
    input  logic [XLEN-1:0] lsu_wdata,
    output logic            lsu_gnt,
    output logic            lsu_rvalid,
    output logic [XLEN-1:0] lsu_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);
    localparam int SW = $clog2(MAX_STREAK + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

    state_e          state_q;
    logic            owner_lsu_q;
    logic [SW-1:0]   streak_q;
    logic [SW-1:0]   streak_d;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic            ifu_gnt_q;
    logic            lsu_gnt_q;
    logic            pick_lsu;

    // IFU overrides LSU only once the streak has reached its limit.
    assign pick_lsu = lsu_req && !(ifu_req && (streak_q == SW'(MAX_STREAK)));

    // Streak only grows while IFU is actually waiting; any other grant resets it.
    always_comb begin
        streak_d = '0;
        if (pick_lsu && ifu_req)
            streak_d = (streak_q == SW'(MAX_STREAK)) ? streak_q : streak_q + SW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_lsu_q <= 1'b0;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ifu_gnt_q   <= 1'b0;
            lsu_gnt_q   <= 1'b0;
        end else begin
            ifu_gnt_q <= 1'b0;
            lsu_gnt_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ifu_req || lsu_req) begin
                        state_q     <= S_ISSUE;
                        owner_lsu_q <= pick_lsu;
                        streak_q    <= streak_d;
                        mem_req_q   <= 1'b1;
                        ifu_gnt_q   <= !pick_lsu;
                        lsu_gnt_q   <= pick_lsu;
                        if (pick_lsu) begin
                            mem_we_q    <= lsu_we;
                            mem_addr_q  <= lsu_addr;
                            mem_wdata_q <= lsu_wdata;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= ifu_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= mem_we_q ? S_IDLE : S_RESP;
                    end
                end
                S_RESP: begin
                    if (mem_rvalid)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ifu_gnt   = ifu_gnt_q;
    assign lsu_gnt   = lsu_gnt_q;

    // Responses pass straight through; only RESP qualifies them, so stray
    // mem_rvalid in other states (or after a reset) is dropped.
    assign ifu_rvalid = (state_q == S_RESP) && !owner_lsu_q && mem_rvalid;
    assign lsu_rvalid = (state_q == S_RESP) &&  owner_lsu_q && mem_rvalid;
    assign ifu_rdata  = mem_rdata;
    assign lsu_rdata  = mem_rdata;

endmodule

// File: tb/tb_cpu5_mem_arbiter.sv
module tb_cpu5_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ifu_req = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        ifu_gnt, ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        lsu_req = 1'b0, lsu_we = 1'b0;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic        lsu_gnt, lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    cpu5_mem_arbiter #(.XLEN(32), .MAX_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // event kinds: 0 ifu_gnt, 1 lsu_gnt, 2 ifu_rvalid, 3 lsu_rvalid
    typedef struct {
        int          kind;
        logic [31:0] data;
    } ev_t;
    ev_t exp_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic mon(input int k, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual_kind=%0d expected=none t=%0t", k, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            if (k >= 2) chk("event_rdata", d, e.data);
        end
    endtask

    // Monitor: every output pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!reset) begin
            chk("gnt_exclusive", {31'b0, ifu_gnt & lsu_gnt}, 32'd0);
            chk("rvalid_exclusive", {31'b0, ifu_rvalid & lsu_rvalid}, 32'd0);
            if (ifu_gnt)    mon(0, 32'd0);
            if (lsu_gnt)    mon(1, 32'd0);
            if (ifu_rvalid) mon(2, ifu_rdata);
            if (lsu_rvalid) mon(3, lsu_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_mem_req"}, {31'b0, mem_req}, 32'd0);
        chk({nm, "_mem_we"}, {31'b0, mem_we}, 32'd0);
        chk({nm, "_mem_addr"}, mem_addr, 32'd0);
        chk({nm, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({nm, "_gnts"}, {30'b0, ifu_gnt, lsu_gnt}, 32'd0);
        chk({nm, "_rvalids"}, {30'b0, ifu_rvalid, lsu_rvalid}, 32'd0);
    endtask

    initial begin
        #3;
        chk_outputs_zero("reset_state");
        tick(); tick();
        reset = 1'b0;
        tick();

        // 1: IFU read 0x100, immediate accept, data one cycle later
        push(0, 0); push(2, 32'hDEADBEEF);
        ifu_req = 1'b1; ifu_addr = 32'h100;
        tick();                                    // ISSUE
        ifu_req = 1'b0; mem_ready = 1'b1;
        #3;
        chk("t1_ifu_gnt", {31'b0, ifu_gnt}, 32'd1);
        chk("t1_mem_req", {31'b0, mem_req}, 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_we", {31'b0, mem_we}, 32'd0);
        tick();                                    // RESP
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        #3;
        chk("t1_ifu_rvalid", {31'b0, ifu_rvalid}, 32'd1);
        chk("t1_lsu_rvalid", {31'b0, lsu_rvalid}, 32'd0);
        tick();                                    // IDLE
        mem_rvalid = 1'b0;

        // 2: LSU store, mem_ready low 3 cycles, request must hold stable
        push(1, 0);
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h200; lsu_wdata = 32'h12345678;
        tick();                                    // ISSUE
        lsu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #3;
            chk("t2_mem_req", {31'b0, mem_req}, 32'd1);
            chk("t2_mem_we", {31'b0, mem_we}, 32'd1);
            chk("t2_mem_addr", mem_addr, 32'h200);
            chk("t2_mem_wdata", mem_wdata, 32'h12345678);
            tick();
        end
        mem_ready = 1'b0;
        #3;
        chk("t2_idle_mem_req", {31'b0, mem_req}, 32'd0);
        tick();

        // 3: simultaneous IFU + LSU load: LSU first, IFU one cycle after IDLE
        push(1, 0); push(3, 32'hA5A5_0001); push(0, 0); push(2, 32'hB0B0_0002);
        ifu_req = 1'b1; ifu_addr = 32'h104;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h300;
        tick();                                    // ISSUE (LSU)
        lsu_req = 1'b0; mem_ready = 1'b1;
        #3;
        chk("t3_first_addr", mem_addr, 32'h300);
        tick();                                    // RESP
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0001;
        tick();                                    // IDLE
        mem_rvalid = 1'b0;
        #3;
        chk("t3_idle_no_gnt", {30'b0, ifu_gnt, mem_req}, 32'd0);
        tick();                                    // ISSUE (IFU)
        ifu_req = 1'b0; mem_ready = 1'b1;
        #3;
        chk("t3_ifu_gnt", {31'b0, ifu_gnt}, 32'd1);
        chk("t3_ifu_addr", mem_addr, 32'h104);
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hB0B0_0002;
        tick();
        mem_rvalid = 1'b0;

        // 4: starvation bound: LSU x4, IFU, LSU x4, IFU
        ifu_req = 1'b1; ifu_addr = 32'h108;
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h400; lsu_wdata = 32'h1;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) begin
                push(0, 0); push(2, 32'h5000 + k);
            end else begin
                push(1, 0);
            end
        end
        for (int k = 0; k < 10; k++) begin
            tick();                                // ISSUE
            mem_ready = 1'b1;
            if (k % 5 == 4) begin
                tick();                            // RESP
                mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5000 + k;
                tick();                            // IDLE
                mem_rvalid = 1'b0;
            end else begin
                tick();                            // IDLE
                mem_ready = 1'b0;
            end
        end
        ifu_req = 1'b0; lsu_req = 1'b0;
        tick();

        // 5: async reset mid-read in RESP, late response dropped
        push(0, 0);
        ifu_req = 1'b1; ifu_addr = 32'h180;
        tick();                                    // ISSUE
        ifu_req = 1'b0; mem_ready = 1'b1;
        tick();                                    // RESP
        mem_ready = 1'b0;
        #1;
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        #1;
        chk_outputs_zero("t5_async_reset");
        tick();
        reset = 1'b0;
        tick();                                    // late mem_rvalid while IDLE
        mem_rvalid = 1'b0;
        push(1, 0); push(3, 32'hCAFEF00D);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h404;
        tick();
        lsu_req = 1'b0; mem_ready = 1'b1;
        #3;
        chk("t5_post_reset_addr", mem_addr, 32'h404);
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_rvalid = 1'b0;

        // 6: spurious mem_rvalid in IDLE and in ISSUE
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_rvalid = 1'b0;
        push(1, 0); push(3, 32'h2222_2222);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h500;
        tick();                                    // ISSUE
        lsu_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
        tick();                                    // still ISSUE
        mem_rvalid = 1'b0; mem_ready = 1'b1;
        #3;
        chk("t6_still_issue", {31'b0, mem_req}, 32'd1);
        tick();                                    // RESP
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
        tick();
        mem_rvalid = 1'b0;
        tick();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu5_mem_arbiter.md
# cpu5_mem_arbiter

Shares one single-ported memory between the instruction-fetch side and the load/store side of the cpu5 core, so the core can run against one unified memory instead of split instruction/data ports. It arbitrates between the two requesters and holds the chosen request on the memory port until the memory accepts it. For reads, it routes the response back to the owner. Only one memory transaction is outstanding at any time. Loads/stores have priority, with a bounded-starvation guarantee for fetch.

## Interface
- XLEN, 32, address/data width (matches `CPU5_XLEN`)
- MAX_STREAK, 4, max consecutive LSU grants while IFU is waiting (must be ≥1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- ifu_req  in  1  fetch read request; held with ifu_addr until ifu_gnt
- ifu_addr  in  XLEN  fetch address
- ifu_gnt  out  1  one-cycle pulse: fetch request taken
- ifu_rvalid  out  1  fetch data valid (one cycle)
- ifu_rdata  out  XLEN  fetch data
- lsu_req  in  1  load/store request; held with payload until lsu_gnt
- lsu_we  in  1  1 = store, 0 = load
- lsu_addr  in  XLEN  data address
- lsu_wdata  in  XLEN  store data
- lsu_gnt  out  1  one-cycle pulse: data request taken
- lsu_rvalid  out  1  load data valid (one cycle)
- lsu_rdata  out  XLEN  load data
- mem_req  out  1  memory request valid
- mem_we  out  1  memory write enable
- mem_addr  out  XLEN  memory address
- mem_wdata  out  XLEN  memory write data
- mem_ready  in  1  memory accepts request this cycle (when mem_req=1)
- mem_rvalid  in  1  read response valid
- mem_rdata  in  XLEN  read response data

## Operation
- State machine with three states:
  - IDLE: no transaction.
  - ISSUE: request is on the memory port.
  - RESP: waiting for read data.
- Owner register records which side owns the current transaction (IFU or LSU).
- Request registers latch addr, we, and wdata when a request is granted.
- IDLE transitions:
  - If any request is high, pick a winner, latch its payload, and go to ISSUE.
  - An IFU request is latched with we=0 and wdata=0.
- Winner selection:
  - Only LSU requesting: LSU wins. Only IFU requesting: IFU wins.
  - Both requesting: LSU wins unless streak == MAX_STREAK, in which case IFU wins.
- Streak counter, width clog2(MAX_STREAK+1):
  - Increments (saturating) when LSU wins while ifu_req=1.
  - Clears when IFU wins, or when a grant happens with ifu_req=0.
- ISSUE:
  - mem_req=1, driven from the latched registers.
  - The grant for the owner pulses in the first ISSUE cycle only.
  - On mem_ready=1: a store goes to IDLE; a read goes to RESP.
- RESP:
  - On mem_rvalid=1, the owner's rvalid goes to 1 and its rdata equals mem_rdata, combinationally, in the same cycle.
  - Then go to IDLE.
- Requests are sampled only in IDLE. A requester still asserting req after its gnt is treated as a new request.
- mem_rvalid outside RESP is ignored: no rvalid is produced.
- Stores produce no rvalid.
- rdata outputs equal mem_rdata at all times; they are meaningful only while the matching rvalid is high.

## Timing
- Reset (async) takes effect immediately, mid-transaction included:
  - State = IDLE, streak = 0, mem_req = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - All gnt and rvalid outputs = 0.
  - A response still in flight from before the reset is discarded.
- Request high in IDLE at edge N: ISSUE starts at N+1, where mem_req=1 and gnt=1 together.
- Store with mem_ready in its first ISSUE cycle: back in IDLE at N+2, so the minimum store cadence is 2 cycles.
- Read with mem_ready on the first ISSUE cycle and mem_rvalid on the first RESP cycle: rvalid in cycle N+2, IDLE at N+3, so the minimum read cadence is 3 cycles.
- mem_req, mem_we, mem_addr and mem_wdata are registered and held stable while mem_ready=0.
- gnt never asserts to both sides in the same cycle.
- rvalid never asserts to both sides in the same cycle.
- Concurrent ifu_req/lsu_req changes outside IDLE have no effect.

## Test plan
- IFU read, addr 0x100, mem_ready=1 at once, mem_rvalid with 0xDEADBEEF one cycle later -> ifu_gnt pulse at cycle 1; ifu_rvalid=1 with ifu_rdata=0xDEADBEEF at cycle 2; lsu_rvalid stays 0.
- LSU store, addr 0x200, wdata 0x12345678, mem_ready held low for 3 cycles -> mem_req/mem_we/mem_addr/mem_wdata stable for 4 cycles; lsu_gnt pulses once; no rvalid; IDLE the cycle after acceptance.
- ifu_req and lsu_req (load) asserted together -> LSU served first, then IFU; ifu_gnt exactly 1 cycle after the LSU transaction returns to IDLE.
- ifu_req held high with lsu_req continuously high (MAX_STREAK=4) -> grant order LSU ×4, IFU, LSU ×4, IFU.
- Async reset asserted in RESP mid-read, then mem_rvalid arrives after release -> all outputs 0 immediately; the late mem_rvalid produces no rvalid; next request is served normally.
- Spurious mem_rvalid in IDLE and in ISSUE -> no ifu_rvalid/lsu_rvalid; state unaffected.
